// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, default
// geometry and byte-to-word address helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 32;
    localparam int MEM_WORDS_DEF = 65;

    // Widest byte address the helper accepts; callers zero-extend into it.
    localparam int MAX_ADDR_W = 64;

    function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             found,
    output logic [PTR_W-1:0] winner
);

    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] slot_idx [N_REQ];
    logic [N_REQ-1:0] hit;

    // slot gi is the requester gi positions after rr_ptr; one subtraction
    // suffices because both operands are below N_REQ.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        logic [SUM_W-1:0] sum;
        assign sum = {1'b0, rr_ptr} + SUM_W'(gi);
        assign slot_idx[gi] = (sum >= SUM_W'(N_REQ)) ? PTR_W'(sum - SUM_W'(N_REQ))
                                                     : sum[PTR_W-1:0];
        assign hit[gi] = req[slot_idx[gi]];
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found  = 1'b1;
                winner = slot_idx[k];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between N_REQ requesters.
// Each transaction takes IDLE -> ACCESS -> DONE, acking in DONE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ack,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_a,
    output logic [DATA_W-1:0]        mem_wd,
    input  logic [DATA_W-1:0]        mem_rd
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              found;
    logic [PTR_W-1:0]  winner;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (found),
        .winner (winner)
    );

    assign sel_addr  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(winner)*DATA_W +: DATA_W];
    assign sel_oor   = word_index(MAX_ADDR_W'(sel_addr)) >= MAX_ADDR_W'(MEM_WORDS);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        oor_d        = oor_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = winner;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = req_we[winner];
                    oor_d   = sel_oor;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Writes and out-of-range reads report zero data.
                resp_rdata_d = (we_q | oor_q) ? '0 : mem_rd;
                resp_err_d   = oor_q;
                rr_ptr_d     = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d      = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Gating with rst_n lets a reset asserted mid-transaction kill the
    // negedge write and the ack immediately.
    assign mem_we = we_q & ~oor_q & (state_q == ACCESS) & rst_n;
    assign mem_a  = addr_q;
    assign mem_wd = wdata_q;

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        req_ack = '0;
        if (state_q == DONE && rst_n) begin
            req_ack[win_q] = 1'b1;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between N_REQ requesters (cores / DMA) using round-robin arbitration.
- Each requester issues a word read or write through a valid/ack handshake.
- The block drives the memory's we/a/wd port, samples rd, and returns the read data to the winner.
- Sits between the per-core memory stages and the data memory instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data width.
- ADDR_W, 32, byte address width; word index = addr[ADDR_W-1:2].
- MEM_WORDS, 65, words implemented in the data memory; higher word indices are out of range.

Ports:
- clk  in  1  system clock; memory writes on negedge, arbiter logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester request.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  flattened byte addresses; slot i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  flattened write data.
- req_ack  out  N_REQ  one-hot, one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data, valid while req_ack is nonzero.
- resp_err  out  1  out-of-range flag, valid while req_ack is nonzero.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDR_W  memory byte address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory combinational read data.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, rr_ptr=0.
  - req_ack=0, resp_rdata=0, resp_err=0.
  - mem_a=0, mem_wd=0, latched we_q=0.
- FSM IDLE:
  - If any req_valid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Latch the winner index, addr, wdata, we and the range flag (addr[ADDR_W-1:2] >= MEM_WORDS).
  - Go to ACCESS. With no requests, stay in IDLE.
- FSM ACCESS (exactly 1 cycle):
  - mem_a and mem_wd come from the latched registers.
  - mem_we = we_q & ~oor_q & (state==ACCESS) & rst_n, combinational. The negedge write therefore fires only inside ACCESS, and a reset asserted during ACCESS suppresses the write.
  - At the closing posedge, capture resp_rdata = (we_q | oor_q) ? 0 : mem_rd.
  - Set resp_err=oor_q, rr_ptr=(winner+1) mod N_REQ, then go to DONE.
- FSM DONE (1 cycle):
  - req_ack[winner]=1; resp_rdata and resp_err are valid.
  - Next state is always IDLE.
- req_ack is low in every other state. resp_rdata and resp_err hold their value until the next DONE.
- Latency and throughput:
  - A request sampled in IDLE at cycle t is acked in cycle t+2.
  - At most one transaction every 3 cycles.
  - IDLE after DONE guarantees the acked requester's deassertion is seen before re-arbitration.
- Requester rules:
  - Hold req_valid, req_we, req_addr and req_wdata stable until the ack cycle, then drop req_valid (or present a new request) at the following edge.
  - Changing fields before ack is illegal. The arbiter uses only the values latched in IDLE.
- Boundaries:
  - All requesters valid: grants rotate 0,1,2,3,0...
  - A single requester that holds valid continuously is served back to back with a 3-cycle period.
  - rr_ptr wraps from N_REQ-1 to 0.
  - An out-of-range write leaves memory untouched. An out-of-range read returns 0 with resp_err=1.
  - Unaligned addr[1:0] is ignored (word access).
- Reset in ACCESS or DONE aborts the transaction: no ack, no write, rr_ptr=0.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE), 2 bits;
  - the default N_REQ, DATA_W, ADDR_W and MEM_WORDS constants;
  - a function for word index extraction.
- Sub-module rr_picker (combinational): inputs req vector and rr_ptr; outputs found and winner index (clog2(N_REQ) bits).
- The FSM, latches and memory drive live in dmem_arbiter.

Test Plan:
- Read: memory word 5 preloaded with 0xDEADBEEF; req1 read addr 0x14 → req_ack[1] pulses 2 cycles after sampling, resp_rdata=0xDEADBEEF, resp_err=0, mem_we never high.
- Write then read: req0 writes 0x12345678 to addr 0x08 → mem_we high for exactly one cycle with mem_a=0x08; a subsequent req0 read of 0x08 returns 0x12345678.
- Contention: all 4 requesters hold reads continuously → ack order 0,1,2,3,0; acks spaced every 3 cycles.
- Out of range: req2 write to 0x104 (word 65) → mem_we stays 0, ack with resp_err=1, resp_rdata=0; word 64 is still accepted.
- Reset during ACCESS: rst_n low during the ACCESS cycle of a write → no memory change, no ack, state IDLE, rr_ptr=0.
- Wrap: req3 acked, then req0 and req3 request together → req0 is granted first (rr_ptr wrapped to 0).
